// File: rtl/decoder_pkg.sv
// Shared types and helpers for the strobe decoder family: FSM state,
// command mode encoding and the idle (inactive) level of the strobe lines.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic MODE_HOLD  = 1'b0;
   localparam logic MODE_PULSE = 1'b1;

   // Idle level of a strobe bus: all-ones for active-low lines, else all-zeros.
   // Returned at full 64-bit width; callers truncate to their line count.
   function automatic logic [63:0] inactive_level(input logic active_low,
                                                  input int unsigned width);
      logic [63:0] level;
      level = '0;
      if (active_low) begin
         for (int i = 0; i < 64; i++) begin
            if (i < int'(width)) begin
               level[i] = 1'b1;
            end
         end
      end
      return level;
   endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Purely combinational SEL_W -> 2**SEL_W one-hot decoder (active-high).
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W = 4
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [2**SEL_W-1:0]   lines
);

   always_comb begin
      lines      = '0;
      lines[sel] = 1'b1;
   end

endmodule

// File: rtl/decoder_strobe_seq.sv
// Registered 1-of-2**SEL_W strobe decoder with valid/ready command handshake,
// timed-pulse and latched-hold modes, and selectable output polarity.
module decoder_strobe_seq
   import decoder_pkg::*;
#(
   parameter int SEL_W      = 4,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int CNT_W      = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  en_n_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [SEL_W-1:0]      sel_in,
   input  logic                  mode_in,
   input  logic [CNT_W-1:0]      width_in,
   input  logic                  release_in,
   output logic [2**SEL_W-1:0]   y_out,
   output logic                  busy_out
);

   localparam int LINES = 2**SEL_W;
   localparam logic [LINES-1:0] INACTIVE = LINES'(inactive_level(ACTIVE_LOW, LINES));

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   count;
   logic               accept;
   logic [LINES-1:0]   decoded;
   logic [LINES-1:0]   strobe;

   decoder_onehot #(
      .SEL_W (SEL_W)
   ) u_onehot (
      .sel   (sel_in),
      .lines (decoded)
   );

   assign strobe = ACTIVE_LOW ? ~decoded : decoded;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A disable always wins; in HOLD a fresh accept takes priority over release.
   always_comb begin
      next_state = state;
      if (en_n_in) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  next_state = (mode_in == MODE_PULSE) ? PULSE : HOLD;
               end else if ((state == HOLD) && release_in) begin
                  next_state = IDLE;
               end
            end
            PULSE: begin
               if (count == '0) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      ready_out = ~en_n_in & ((state == IDLE) || (state == HOLD));
      accept    = valid_in & ready_out;
      busy_out  = (state != IDLE);
   end

   // Loaded with max(width,1)-1 so the line stays up for exactly width cycles.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count <= '0;
      end else if (en_n_in) begin
         count <= '0;
      end else if (accept) begin
         if ((mode_in == MODE_PULSE) && (width_in != '0)) begin
            count <= width_in - CNT_W'(1);
         end else begin
            count <= '0;
         end
      end else if ((state == PULSE) && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   // Switching lines is a single register update, so no overlap and no gap.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         y_out <= INACTIVE;
      end else if (next_state == IDLE) begin
         y_out <= INACTIVE;
      end else if (accept) begin
         y_out <= strobe;
      end
   end

endmodule

// File: tb/tb_decoder_strobe_seq.sv
// Self-checking bench: directed test-plan sequences then randomized traffic,
// three DUT configurations compared every cycle against a behavioural model.
module tb_decoder_strobe_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_n = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  sel = '0;
   logic [5:0]  sel6 = '0;
   logic        mode = 1'b0;
   logic [7:0]  width = '0;
   logic        rel = 1'b0;

   logic        ready4, busy4, ready2, busy2, ready6, busy6;
   logic [15:0] y4;
   logic [3:0]  y2;
   logic [63:0] y6;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decoder_strobe_seq #(.SEL_W(4), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut4 (
      .clk_in(clk), .rst_n_in(rst_n), .en_n_in(en_n), .valid_in(valid),
      .ready_out(ready4), .sel_in(sel), .mode_in(mode), .width_in(width),
      .release_in(rel), .y_out(y4), .busy_out(busy4));

   decoder_strobe_seq #(.SEL_W(2), .ACTIVE_LOW(1'b0), .CNT_W(8)) dut2 (
      .clk_in(clk), .rst_n_in(rst_n), .en_n_in(en_n), .valid_in(valid),
      .ready_out(ready2), .sel_in(sel[1:0]), .mode_in(mode), .width_in(width),
      .release_in(rel), .y_out(y2), .busy_out(busy2));

   decoder_strobe_seq #(.SEL_W(6), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut6 (
      .clk_in(clk), .rst_n_in(rst_n), .en_n_in(en_n), .valid_in(valid),
      .ready_out(ready6), .sel_in(sel6), .mode_in(mode), .width_in(width),
      .release_in(rel), .y_out(y6), .busy_out(busy6));

   // Behavioural model: is a line up, which one, and how many cycles remain.
   bit m_active = 1'b0;
   bit m_pulse = 1'b0;
   int m_remaining = 0;
   int m_line4 = 0;
   int m_line6 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
      end else if (en_n) begin
         m_active = 1'b0;
      end else if (valid && !(m_active && m_pulse)) begin
         m_active    = 1'b1;
         m_pulse     = mode;
         m_line4     = int'(sel);
         m_line6     = int'(sel6);
         m_remaining = (width == 0) ? 1 : int'(width);
      end else if (m_active && m_pulse) begin
         m_remaining = m_remaining - 1;
         if (m_remaining == 0) m_active = 1'b0;
      end else if (m_active && rel) begin
         m_active = 1'b0;
      end
   end

   function automatic logic [15:0] exp_y4();
      logic [15:0] one = 16'h0001;
      return m_active ? ~(one << m_line4) : 16'hFFFF;
   endfunction

   function automatic logic [3:0] exp_y2();
      logic [3:0] one = 4'h1;
      return m_active ? (one << (m_line4 % 4)) : 4'h0;
   endfunction

   function automatic logic [63:0] exp_y6();
      logic [63:0] one = 64'h1;
      return m_active ? ~(one << m_line6) : {64{1'b1}};
   endfunction

   function automatic logic exp_ready();
      return !en_n && !(m_active && m_pulse);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("model_y4", 64'(y4), 64'(exp_y4()));
      checkOutput("model_y2", 64'(y2), 64'(exp_y2()));
      checkOutput("model_y6", y6, exp_y6());
      checkOutput("model_ready", {61'd0, ready4, ready2, ready6}, {61'd0, {3{exp_ready()}}});
      checkOutput("model_busy", {61'd0, busy4, busy2, busy6}, {61'd0, {3{m_active}}});
      checks++;
      assert ($onehot0(~y4) && $onehot0(y2) && $onehot0(~y6)) else begin
         failures++;
         $error("[TB] FAIL onehot: y4=%0h y2=%0h y6=%0h", y4, y2, y6);
      end
   end

   task automatic applyStimulus(input logic v, input logic [3:0] s, input logic m,
                                input logic [7:0] w, input logic r, input logic e);
      valid = v;
      sel   = s;
      sel6  = {2'b10, s};
      mode  = m;
      width = w;
      rel   = r;
      en_n  = e;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic sampleY(input string name, input logic [15:0] exp);
      @(negedge clk);
      checkOutput(name, 64'(y4), 64'(exp));
   endtask

   initial begin
      applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_y4", 64'(y4), 64'hFFFF);
      checkOutput("reset_y2", 64'(y2), 64'h0);
      checkOutput("reset_busy", 64'(busy4), 64'd0);
      checkOutput("reset_ready", 64'(ready4), 64'd1);
      nextCycle();
      rst_n = 1'b1;

      // Pulse sel=5 width=3
      applyStimulus(1'b1, 4'd5, 1'b1, 8'd3, 1'b0, 1'b0);
      nextCycle();
      valid = 1'b0;
      sampleY("pulse_c1", 16'hFFDF);
      checkOutput("pulse_ready0", 64'(ready4), 64'd0);
      nextCycle(); sampleY("pulse_c2", 16'hFFDF);
      nextCycle(); sampleY("pulse_c3", 16'hFFDF);
      nextCycle(); sampleY("pulse_end", 16'hFFFF);
      checkOutput("pulse_ready1", 64'(ready4), 64'd1);

      // Width 0 behaves as a single cycle
      applyStimulus(1'b1, 4'd7, 1'b1, 8'd0, 1'b0, 1'b0);
      nextCycle();
      valid = 1'b0;
      sampleY("w0_c1", 16'hFF7F);
      nextCycle(); sampleY("w0_end", 16'hFFFF);

      // Hold, switch, release
      applyStimulus(1'b1, 4'd2, 1'b0, 8'd0, 1'b0, 1'b0);
      nextCycle();
      sampleY("hold_2", 16'hFFFB);
      checkOutput("hold_busy", 64'(busy4), 64'd1);
      checkOutput("hold_ready", 64'(ready4), 64'd1);
      applyStimulus(1'b1, 4'd14, 1'b0, 8'd0, 1'b0, 1'b0);
      nextCycle();
      valid = 1'b0;
      sampleY("hold_14", 16'hBFFF);
      rel = 1'b1;
      nextCycle();
      rel = 1'b0;
      sampleY("release", 16'hFFFF);
      checkOutput("release_busy", 64'(busy4), 64'd0);

      // Accept together with release: the new line is held
      applyStimulus(1'b1, 4'd3, 1'b0, 8'd0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 4'd8, 1'b0, 8'd0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'd8, 1'b0, 8'd0, 1'b0, 1'b0);
      sampleY("accept_beats_release", 16'hFEFF);
      rel = 1'b1;
      nextCycle();
      rel = 1'b0;

      // valid held through a width=4 pulse; later command waits for ready
      applyStimulus(1'b1, 4'd0, 1'b1, 8'd4, 1'b0, 1'b0);
      nextCycle();
      sel = 4'd9;
      sel6 = 6'd9;
      sampleY("busy_c1", 16'hFFFE);
      checkOutput("busy_ready0", 64'(ready4), 64'd0);
      nextCycle(); sampleY("busy_c2", 16'hFFFE);
      nextCycle(); sampleY("busy_c3", 16'hFFFE);
      nextCycle(); sampleY("busy_c4", 16'hFFFE);
      nextCycle(); sampleY("busy_gap", 16'hFFFF);
      checkOutput("busy_gap_ready", 64'(ready4), 64'd1);
      nextCycle();
      valid = 1'b0;
      sampleY("busy_second", 16'hFDFF);
      repeat (4) nextCycle();

      // Enable abort during a width=10 pulse
      applyStimulus(1'b1, 4'd4, 1'b1, 8'd10, 1'b0, 1'b0);
      nextCycle();
      valid = 1'b0;
      sampleY("abort_c1", 16'hFFEF);
      nextCycle();
      en_n = 1'b1;
      sampleY("abort_c2", 16'hFFEF);
      checkOutput("abort_ready", 64'(ready4), 64'd0);
      nextCycle();
      sampleY("abort_idle", 16'hFFFF);
      checkOutput("abort_busy", 64'(busy4), 64'd0);
      en_n = 1'b0;
      nextCycle();
      applyStimulus(1'b1, 4'd1, 1'b0, 8'd0, 1'b0, 1'b0);
      nextCycle();
      valid = 1'b0;
      sampleY("abort_fresh", 16'hFFFD);

      // Async reset mid-hold, between edges
      nextCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("async_y4", 64'(y4), 64'hFFFF);
      checkOutput("async_y2", 64'(y2), 64'h0);
      checkOutput("async_busy", 64'(busy4), 64'd0);
      nextCycle();
      rst_n = 1'b1;

      // Randomized traffic, including occasional mid-cycle resets
      for (int i = 0; i < 3000; i++) begin
         nextCycle();
         valid = ($urandom_range(0, 1) == 1);
         sel   = 4'($urandom);
         sel6  = 6'($urandom);
         mode  = ($urandom_range(0, 1) == 1);
         width = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
         rel   = ($urandom_range(0, 3) == 0);
         en_n  = ($urandom_range(0, 19) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
      end
      nextCycle();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
